// File: rtl/cache_port_arbiter_pkg.sv
// Shared definitions for the cache port arbiter.
//   arb_state_e         : transaction FSM states (idle, request, response)
//   DEFAULT_NUM_MASTERS : default number of core-side masters
//   DEFAULT_ADDR_WIDTH  : default request address width
package cache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_RESPONSE = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_NUM_MASTERS = 2;
    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req_i    : request vector, one bit per master
//   ptr_i    : highest-priority index for this pick
//   winner_o : first requesting index at or after ptr_i (modulo NUM_MASTERS)
//   valid_o  : at least one request present
module rr_priority_picker
    import cache_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEFAULT_NUM_MASTERS,
    localparam int unsigned IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic [IDX_W-1:0]       winner_o,
    output logic                   valid_o
);

    int unsigned idx;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        // Walk offsets 0..N-1 from the pointer; the first hit wins.
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            idx = (32'(ptr_i) + k) % NUM_MASTERS;
            if (!valid_o && req_i[IDX_W'(idx)]) begin
                winner_o = IDX_W'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache core-side port between masters.
// At most one transaction is outstanding at the shared port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   m_req_i .. m_be_i     : per-master request (packed, master k in slice k)
//   m_gnt_o, m_rvalid_o   : per-master grant / response valid
//   m_error_o             : per-master error, valid with m_rvalid_o
//   m_rdata_o             : response data broadcast to all masters
//   s_req_o .. s_be_o     : shared cache request
//   s_gnt_i .. s_error_i  : shared cache grant / response
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*32-1:0]         m_wdata_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*4-1:0]          m_be_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic [31:0]                       m_rdata_o,
    output logic [NUM_MASTERS-1:0]            m_error_o,
    output logic                              s_req_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [31:0]                       s_wdata_o,
    output logic                              s_we_o,
    output logic [3:0]                        s_be_o,
    input  logic                              s_gnt_i,
    input  logic                              s_rvalid_i,
    input  logic [31:0]                       s_rdata_i,
    input  logic                              s_error_i
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    arb_state_e              state_q;
    logic [IDX_W-1:0]        sel_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        winner;
    logic                    any_req;
    logic [IDX_W-1:0]        sel_next;
    logic [NUM_MASTERS-1:0]  sel_onehot;
    logic                    granted;
    logic                    complete;
    logic                    active;

    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_wdata;
    logic                    sel_we;
    logic [3:0]              sel_be;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req_i    (m_req_i),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .valid_o  (any_req)
    );

    assign sel_next = (sel_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel_q + 1'b1;

    // Grant is only meaningful while requesting; a response completes either
    // in Response or in Request when the cache grants and responds together.
    assign granted  = (state_q == ST_REQUEST) && s_gnt_i;
    assign complete = ((state_q == ST_RESPONSE) && s_rvalid_i) || (granted && s_rvalid_i);
    assign active   = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        sel_q   <= winner;
                        state_q <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (s_gnt_i) begin
                        if (s_rvalid_i) begin
                            rr_ptr_q <= sel_next;
                            state_q  <= ST_IDLE;
                        end else begin
                            state_q  <= ST_RESPONSE;
                        end
                    end
                end
                ST_RESPONSE: begin
                    if (s_rvalid_i) begin
                        rr_ptr_q <= sel_next;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_we     = 1'b0;
        sel_be     = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (sel_q == IDX_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_addr      = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata     = m_wdata_i[k*32 +: 32];
                sel_we        = m_we_i[k];
                sel_be        = m_be_i[k*4 +: 4];
            end
        end
    end

    // Request fields are forced to zero in Idle so reset and idle look alike.
    assign s_req_o    = (state_q == ST_REQUEST);
    assign s_addr_o   = active ? sel_addr  : '0;
    assign s_wdata_o  = active ? sel_wdata : '0;
    assign s_we_o     = active ? sel_we    : 1'b0;
    assign s_be_o     = active ? sel_be    : '0;

    assign m_gnt_o    = granted  ? sel_onehot : '0;
    assign m_rvalid_o = complete ? sel_onehot : '0;
    assign m_error_o  = (complete && s_error_i) ? sel_onehot : '0;
    assign m_rdata_o  = s_rdata_i;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a 2-master instance for the main
// scenarios and a 3-master instance for round-robin wrap behaviour.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    // 2-master instance
    logic [1:0]  m_req;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_we;
    logic [7:0]  m_be;
    logic [1:0]  m_gnt_o, m_rvalid_o, m_error_o;
    logic [31:0] m_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_gnt, s_rvalid, s_error;
    logic [31:0] s_rdata;

    // 3-master instance
    logic [2:0]  m3_req;
    logic [47:0] m3_addr;
    logic [95:0] m3_wdata;
    logic [2:0]  m3_we;
    logic [11:0] m3_be;
    logic [2:0]  m3_gnt_o, m3_rvalid_o, m3_error_o;
    logic [31:0] m3_rdata_o;
    logic        s3_req_o, s3_we_o;
    logic [15:0] s3_addr_o;
    logic [31:0] s3_wdata_o;
    logic [3:0]  s3_be_o;
    logic        s3_gnt, s3_rvalid, s3_error;
    logic [31:0] s3_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .NUM_MASTERS (2),
        .ADDR_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req_i    (m_req),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_error_o  (m_error_o),
        .s_req_o    (s_req_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata),
        .s_error_i  (s_error)
    );

    cache_port_arbiter #(
        .NUM_MASTERS (3),
        .ADDR_WIDTH  (16)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req_i    (m3_req),
        .m_addr_i   (m3_addr),
        .m_wdata_i  (m3_wdata),
        .m_we_i     (m3_we),
        .m_be_i     (m3_be),
        .m_gnt_o    (m3_gnt_o),
        .m_rvalid_o (m3_rvalid_o),
        .m_rdata_o  (m3_rdata_o),
        .m_error_o  (m3_error_o),
        .s_req_o    (s3_req_o),
        .s_addr_o   (s3_addr_o),
        .s_wdata_o  (s3_wdata_o),
        .s_we_o     (s3_we_o),
        .s_be_o     (s3_be_o),
        .s_gnt_i    (s3_gnt),
        .s_rvalid_i (s3_rvalid),
        .s_rdata_i  (s3_rdata),
        .s_error_i  (s3_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  exp_oh;
        logic [31:0] exp_addr;

        // ---------------- reset state ----------------
        rst_n   = 1'b0;
        m_req   = 2'b11;
        m_addr  = {32'hB000_0000, 32'hA000_0000};
        m_wdata = {32'hFFFF_0000, 32'h0000_FFFF};
        m_we    = 2'b11;
        m_be    = 8'hFF;
        s_gnt = 1'b1; s_rvalid = 1'b1; s_error = 1'b1; s_rdata = 32'h0;
        m3_req = '0; m3_addr = {16'h2222, 16'h1111, 16'h1000};
        m3_wdata = '0; m3_we = '0; m3_be = '0;
        s3_gnt = 1'b0; s3_rvalid = 1'b0; s3_error = 1'b0; s3_rdata = 32'h0;
        #3;
        chk("rst_s_req",    64'(s_req_o),    64'd0);
        chk("rst_s_addr",   64'(s_addr_o),   64'd0);
        chk("rst_s_wdata",  64'(s_wdata_o),  64'd0);
        chk("rst_s_we",     64'(s_we_o),     64'd0);
        chk("rst_s_be",     64'(s_be_o),     64'd0);
        chk("rst_m_gnt",    64'(m_gnt_o),    64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid_o), 64'd0);
        chk("rst_m_error",  64'(m_error_o),  64'd0);
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0; s_error = 1'b0;
        step();
        rst_n = 1'b1;

        // ---------------- single read from master 1 ----------------
        m_req = 2'b10; m_addr = {32'h0000_0040, 32'h0}; m_we = 2'b00; m_be = 8'h0; m_wdata = '0;
        step();
        chk("t1_s_req",       64'(s_req_o),  64'd1);
        chk("t1_s_addr",      64'(s_addr_o), 64'h40);
        chk("t1_gnt_wait",    64'(m_gnt_o),  64'd0);
        step();
        s_gnt = 1'b1; #1;
        chk("t1_gnt",         64'(m_gnt_o),  64'b10);
        step();
        s_gnt = 1'b0; m_req = 2'b00; #1;
        chk("t1_resp_s_req",  64'(s_req_o),  64'd0);
        chk("t1_resp_addr",   64'(s_addr_o), 64'h40);
        chk("t1_gnt_once",    64'(m_gnt_o),  64'd0);
        step();
        s_gnt = 1'b1; #1;
        chk("t1_spur_gnt",    64'(m_gnt_o),  64'd0);
        step();
        s_gnt = 1'b0;
        step();
        chk("t1_no_rv_yet",   64'(m_rvalid_o), 64'd0);
        step();
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; #1;
        chk("t1_rvalid",      64'(m_rvalid_o), 64'b10);
        chk("t1_rdata",       64'(m_rdata_o),  64'hDEAD_BEEF);
        chk("t1_error",       64'(m_error_o),  64'd0);
        step();
        s_rdata = 32'h1111_2222; #1;
        chk("t1_spur_rv_idle", 64'(m_rvalid_o), 64'd0);
        chk("t1_rdata_bcast",  64'(m_rdata_o),  64'h1111_2222);
        chk("t1_idle_s_req",   64'(s_req_o),    64'd0);
        chk("t1_idle_s_addr",  64'(s_addr_o),   64'd0);
        s_rvalid = 1'b0;

        // ---------------- both masters continuously from reset ----------------
        rst_n = 1'b0;
        m_req = 2'b11; m_addr = {32'hB000_0000, 32'hA000_0000};
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000;
            step();
            s_gnt = 1'b1; #1;
            chk("rr_s_req",      64'(s_req_o),  64'd1);
            chk("rr_gnt_order",  64'(m_gnt_o),  64'(exp_oh));
            chk("rr_addr",       64'(s_addr_o), 64'(exp_addr));
            step();
            s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'(k); #1;
            chk("rr_one_outst",  64'(s_req_o),    64'd0);
            chk("rr_rvalid",     64'(m_rvalid_o), 64'(exp_oh));
            step();
            s_rvalid = 1'b0; #1;
            chk("rr_idle_gap",   64'(s_req_o),    64'd0);
        end

        // ---------------- master 0 write ----------------
        m_req   = 2'b01;
        m_addr  = {32'hB000_0000, 32'h0000_0100};
        m_wdata = {32'h0000_CAFE, 32'h1234_5678};
        m_we    = 2'b01;
        m_be    = 8'h3F;
        step();
        s_rvalid = 1'b1; #1;
        chk("wr_we_a",     64'(s_we_o),     64'd1);
        chk("wr_be_a",     64'(s_be_o),     64'hF);
        chk("wr_wdata_a",  64'(s_wdata_o),  64'h1234_5678);
        chk("wr_addr_a",   64'(s_addr_o),   64'h100);
        chk("wr_spur_rv",  64'(m_rvalid_o), 64'd0);
        step();
        s_rvalid = 1'b0; s_gnt = 1'b1; #1;
        chk("wr_we_b",     64'(s_we_o),     64'd1);
        chk("wr_be_b",     64'(s_be_o),     64'hF);
        chk("wr_wdata_b",  64'(s_wdata_o),  64'h1234_5678);
        chk("wr_gnt",      64'(m_gnt_o),    64'b01);
        step();
        s_gnt = 1'b0; m_req = 2'b00; s_rvalid = 1'b1; s_error = 1'b1; #1;
        chk("wr_rvalid",   64'(m_rvalid_o), 64'b01);
        chk("wr_error",    64'(m_error_o),  64'b01);
        chk("wr_we_hold",  64'(s_we_o),     64'd1);
        step();
        s_rvalid = 1'b0; s_error = 1'b0; #1;
        chk("wr_idle_we",  64'(s_we_o),     64'd0);

        // ---------------- gnt and rvalid in the same cycle ----------------
        m_req = 2'b11;
        step();
        s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5A5A_5A5A; #1;
        chk("same_gnt",    64'(m_gnt_o),    64'b10);
        chk("same_rvalid", 64'(m_rvalid_o), 64'b10);
        chk("same_rdata",  64'(m_rdata_o),  64'h5A5A_5A5A);
        m_req = 2'b00;
        step();
        s_gnt = 1'b0; s_rvalid = 1'b0; #1;
        chk("same_idle",   64'(s_req_o),    64'd0);

        // ---------------- reset during Response of master 1 ----------------
        m_req = 2'b10;
        step();
        s_gnt = 1'b1; #1;
        chk("rstmid_gnt",      64'(m_gnt_o),    64'b10);
        step();
        s_gnt = 1'b0; m_req = 2'b00; #1;
        chk("rstmid_resp",     64'(s_req_o),    64'd0);
        rst_n = 1'b0; #1;
        chk("rstmid_addr",     64'(s_addr_o),   64'd0);
        step();
        rst_n = 1'b1; s_rvalid = 1'b1; #1;
        chk("rstmid_no_rv_a",  64'(m_rvalid_o), 64'd0);
        step();
        chk("rstmid_no_rv_b",  64'(m_rvalid_o), 64'd0);
        s_rvalid = 1'b0; m_req = 2'b11;
        step();
        s_gnt = 1'b1; #1;
        chk("rstmid_next_gnt", 64'(m_gnt_o),    64'b01);
        step();
        s_gnt = 1'b0; s_rvalid = 1'b1; m_req = 2'b00; #1;
        chk("rstmid_next_rv",  64'(m_rvalid_o), 64'b01);
        step();
        s_rvalid = 1'b0;

        // ---------------- 3 masters: wrap of the round-robin pointer ----------------
        m3_req = 3'b001;
        step();
        s3_gnt = 1'b1; s3_rvalid = 1'b1; #1;
        chk("m3_first_gnt",  64'(m3_gnt_o),    64'b001);
        m3_req = 3'b000;
        step();
        s3_gnt = 1'b0; s3_rvalid = 1'b0;
        m3_req = 3'b101;
        step();
        s3_gnt = 1'b1; #1;
        chk("m3_ptr1_gnt",   64'(m3_gnt_o),    64'b100);
        chk("m3_ptr1_addr",  64'(s3_addr_o),   64'h2222);
        step();
        s3_gnt = 1'b0; s3_rvalid = 1'b1; #1;
        chk("m3_ptr1_rv",    64'(m3_rvalid_o), 64'b100);
        step();
        s3_rvalid = 1'b0;
        step();
        s3_gnt = 1'b1; #1;
        chk("m3_wrap_gnt",   64'(m3_gnt_o),    64'b001);
        chk("m3_wrap_addr",  64'(s3_addr_o),   64'h1000);
        m3_req = 3'b000;
        step();
        s3_gnt = 1'b0; s3_rvalid = 1'b1; #1;
        chk("m3_wrap_rv",    64'(m3_rvalid_o), 64'b001);
        step();
        s3_rvalid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
